// File: rtl/led_frame_sequencer_if.sv
// Control/strobe bundle between the LED frame sequencer and the pixel
// memory address path / serial shift-register transmitter.
interface led_frame_sequencer_if #(
  parameter int PIX_W = 6,
  parameter int FRM_W = 5
);
  logic             run;
  logic             step;
  logic             hold;
  logic             load_sreg;
  logic             transmit_pixel;
  logic [PIX_W-1:0] pixel;
  logic [FRM_W-1:0] frame;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  modport master (
    input  run, step, hold,
    output load_sreg, transmit_pixel, pixel, frame, frame_start, frame_done, busy
  );

  modport slave (
    output run, step, hold,
    input  load_sreg, transmit_pixel, pixel, frame, frame_start, frame_done, busy
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Pixel/frame walker for a shift-register LED transmitter; every state update
// happens on the falling clock edge. Define FRAME_BOUNCE_EN for ping-pong frame order.
module led_frame_sequencer #(
  parameter int NUM_PIXELS     = 64,
  parameter int NUM_FRAMES     = 24,
  parameter int BITS_PER_PIXEL = 24,
  parameter int CYCLES_PER_BIT = 15,
  parameter int IDLE_CYCLES    = 1000
) (
  input logic                   clk,
  input logic                   rst_n,
  led_frame_sequencer_if.master sif
);
  localparam int PIX_W        = $clog2(NUM_PIXELS);
  localparam int FRM_W        = $clog2(NUM_FRAMES);
  localparam int PIXEL_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;
  localparam int SH_W         = (PIXEL_CYCLES > 1) ? $clog2(PIXEL_CYCLES) : 1;
  localparam int GAP_W        = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(NUM_FRAMES - 1);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(PIXEL_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {STOPPED, READ, LOAD, SHIFT, GAP} state_t;

  state_t           state;
  logic [PIX_W-1:0] pixel;
  logic [FRM_W-1:0] frame;
  logic [SH_W-1:0]  shift_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             step_pending;
  logic             load_sreg;
  logic             transmit_pixel;
  logic             frame_start;
  logic             frame_done;
  logic             busy;
`ifdef FRAME_BOUNCE_EN
  logic             dir_down;
`endif

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state          <= STOPPED;
      pixel          <= '0;
      frame          <= '0;
      shift_cnt      <= '0;
      gap_cnt        <= '0;
      step_pending   <= 1'b0;
      load_sreg      <= 1'b0;
      transmit_pixel <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
`ifdef FRAME_BOUNCE_EN
      dir_down       <= 1'b0;
`endif
    end else begin
      load_sreg      <= 1'b0;
      transmit_pixel <= 1'b0;
      frame_start    <= 1'b0;
      frame_done     <= 1'b0;
      // Requests arriving mid-animation queue one extra frame; later
      // assignments below clear it when a frame actually starts.
      if (sif.step && state != STOPPED) step_pending <= 1'b1;

      case (state)
        STOPPED: begin
          if (sif.run || sif.step || step_pending) begin
            state        <= READ;
            step_pending <= 1'b0;
            frame_start  <= 1'b1;
            busy         <= 1'b1;
          end
        end
        READ: begin
          state     <= LOAD;
          load_sreg <= 1'b1;
        end
        LOAD: begin
          state          <= SHIFT;
          shift_cnt      <= '0;
          transmit_pixel <= 1'b1;
        end
        SHIFT: begin
          if (shift_cnt == SH_LAST) begin
            if (pixel == PIX_LAST) begin
              pixel      <= '0;
              gap_cnt    <= '0;
              state      <= GAP;
              frame_done <= 1'b1;
            end else begin
              pixel <= pixel + PIX_W'(1);
              state <= READ;
            end
          end else begin
            shift_cnt      <= shift_cnt + SH_W'(1);
            transmit_pixel <= 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (!sif.hold) begin
`ifdef FRAME_BOUNCE_EN
              if (!dir_down) begin
                if (frame == FRM_LAST) begin
                  frame    <= frame - FRM_W'(1);
                  dir_down <= 1'b1;
                end else begin
                  frame <= frame + FRM_W'(1);
                end
              end else begin
                if (frame == '0) begin
                  frame    <= FRM_W'(1);
                  dir_down <= 1'b0;
                end else begin
                  frame <= frame - FRM_W'(1);
                end
              end
`else
              frame <= (frame == FRM_LAST) ? '0 : frame + FRM_W'(1);
`endif
            end
            if (sif.run || step_pending || sif.step) begin
              state        <= READ;
              step_pending <= 1'b0;
              frame_start  <= 1'b1;
            end else begin
              state <= STOPPED;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= STOPPED;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sif.load_sreg      = load_sreg;
  assign sif.transmit_pixel = transmit_pixel;
  assign sif.pixel          = pixel;
  assign sif.frame          = frame;
  assign sif.frame_start    = frame_start;
  assign sif.frame_done     = frame_done;
  assign sif.busy           = busy;
endmodule
